// File: rtl/mem_access_ctrl.sv
// Single-request load/store sequencer for the single-port Memory, with a configurable read latency.
// Define MEM_ACCESS_CTRL_WRITE_VERIFY_EN to read back and check every store.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] dataOut
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
        StVerify,
`endif
        StResp
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    assign req_ready = (state_q == StIdle);
    assign busy      = !req_ready;

`ifndef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            rsp_valid <= 1'b0;
            address   <= '0;
            dataIn    <= '0;
            rsp_rdata <= '0;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        address <= req_addr;
                        if (req_write) begin
                            dataIn   <= req_wdata;
                            memWrite <= 1'b1;
                            state_q  <= StWrite;
                        end else begin
                            memRead <= 1'b1;
                            cnt_q   <= CNT_LOAD;
                            state_q <= StRead;
                        end
                    end
                end
                StWrite: begin
                    memWrite <= 1'b0;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
                    // Read-back of the same address starts right after the write strobe.
                    memRead <= 1'b1;
                    cnt_q   <= CNT_LOAD;
                    state_q <= StVerify;
`else
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
`endif
                end
                StRead: begin
                    if (cnt_q == CNT_ONE) begin
                        memRead   <= 1'b0;
                        rsp_rdata <= dataOut;
                        rsp_valid <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StResp;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
                        rsp_err   <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
                StVerify: begin
                    if (cnt_q == CNT_ONE) begin
                        memRead   <= 1'b0;
                        rsp_err   <= (dataOut != dataIn);
                        rsp_valid <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
`endif
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: RD_LAT=1 instance with a combinational-read memory and
// RD_LAT=2 instance with a registered-read memory.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    localparam int VERIFY = 1;
`else
    localparam int VERIFY = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit stuck = 1'b0;

    // RD_LAT=1 instance
    logic        reset1, req_valid1, req_write1, req_ready1, rsp_valid1, rsp_err1, busy1;
    logic        mem_read1, mem_write1;
    logic [4:0]  req_addr1, address1;
    logic [31:0] req_wdata1, rsp_rdata1, data_in1, data_out1;
    logic [31:0] mem1 [32];

    // RD_LAT=2 instance
    logic        reset2, req_valid2, req_write2, req_ready2, rsp_valid2, rsp_err2, busy2;
    logic        mem_read2, mem_write2;
    logic [4:0]  req_addr2, address2;
    logic [31:0] req_wdata2, rsp_rdata2, data_in2, data_out2;
    logic [31:0] mem2 [32];

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_ready(req_ready1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1),
        .memRead(mem_read1), .memWrite(mem_write1), .address(address1), .dataIn(data_in1),
        .dataOut(data_out1)
    );

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(32), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_ready(req_ready2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
        .memRead(mem_read2), .memWrite(mem_write2), .address(address2), .dataIn(data_in2),
        .dataOut(data_out2)
    );

    // Combinational-read memory; optional stuck-at-0 on bit 0 of written data.
    always @(posedge clk) begin
        if (mem_write1) mem1[address1] <= stuck ? (data_in1 & ~32'h1) : data_in1;
    end
    assign data_out1 = mem1[address1];

    // Registered-read memory.
    always @(posedge clk) begin
        if (mem_write2) mem2[address2] <= data_in2;
        if (mem_read2) data_out2 <= mem2[address2];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic test_reset();
        reset1 = 1'b1; reset2 = 1'b1;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
        req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
        repeat (2) @(posedge clk);
        #1 reset1 = 1'b0; reset2 = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready1, busy1, mem_read1, mem_write1, rsp_valid1, rsp_err1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl1: got %b required 100000",
                     {req_ready1, busy1, mem_read1, mem_write1, rsp_valid1, rsp_err1});
        end
        checks++;
        if ({address1, data_in1, rsp_rdata1} !== 69'd0) begin
            errors++;
            $display("FAIL reset_data1: got %h required 0", {address1, data_in1, rsp_rdata1});
        end
        checks++;
        if ({req_ready2, busy2, mem_read2, mem_write2, rsp_valid2, rsp_err2} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl2: got %b required 100000",
                     {req_ready2, busy2, mem_read2, mem_write2, rsp_valid2, rsp_err2});
        end
        checks++;
        if ({address2, data_in2, rsp_rdata2} !== 69'd0) begin
            errors++;
            $display("FAIL reset_data2: got %h required 0", {address2, data_in2, rsp_rdata2});
        end
    endtask

    task automatic test_store();
        int n = 0;
        int extra_wr = 0;
        int rd_seen = 0;
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 5'd23; req_wdata1 = 32'd456;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_write1, mem_read1, busy1, rsp_valid1} !== 4'b1010) begin
            errors++;
            $display("FAIL store_strobe: got wr/rd/busy/rsp=%b required 1010",
                     {mem_write1, mem_read1, busy1, rsp_valid1});
        end
        checks++;
        if (address1 !== 5'd23 || data_in1 !== 32'd456) begin
            errors++;
            $display("FAIL store_addr_data: got %0d/%0d required 23/456", address1, data_in1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (mem_write1) extra_wr++;
            if (mem_read1) rd_seen = 1;
            if (rsp_valid1) break;
        end
        checks++;
        if (n !== 1 + VERIFY) begin
            errors++;
            $display("FAIL store_rsp_latency: got %0d cycles required %0d", n, 1 + VERIFY);
        end
        checks++;
        if (extra_wr !== 0 || rd_seen !== VERIFY) begin
            errors++;
            $display("FAIL store_strobe_count: got extra_wr=%0d rd=%0d required 0/%0d",
                     extra_wr, rd_seen, VERIFY);
        end
        checks++;
        if (rsp_err1 !== 1'b0) begin
            errors++;
            $display("FAIL store_err: got %b required 0", rsp_err1);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid1, req_ready1} !== 2'b01) begin
            errors++;
            $display("FAIL store_idle: got rsp/ready=%b required 01", {rsp_valid1, req_ready1});
        end
    endtask

    task automatic test_load();
        req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 5'd23;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read1, mem_write1, rsp_valid1} !== 3'b100 || address1 !== 5'd23) begin
            errors++;
            $display("FAIL load_strobe: got rd/wr/rsp=%b addr=%0d required 100/23",
                     {mem_read1, mem_write1, rsp_valid1}, address1);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid1, mem_read1, rsp_err1} !== 3'b100) begin
            errors++;
            $display("FAIL load_rsp: got rsp/rd/err=%b required 100",
                     {rsp_valid1, mem_read1, rsp_err1});
        end
        checks++;
        if (rsp_rdata1 !== 32'd456) begin
            errors++;
            $display("FAIL load_rdata: got %0d required 456", rsp_rdata1);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_rdata1 !== 32'd456) begin
            errors++;
            $display("FAIL load_hold: got rsp=%b rdata=%0d required 0/456", rsp_valid1, rsp_rdata1);
        end
    endtask

    task automatic test_back_to_back();
        int busy_n = 0;
        int both = 0;
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 5'd5; req_wdata1 = 32'd7;
        @(posedge clk);
        #1 req_write1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_read1 && mem_write1) both++;
            if (req_ready1) break;
            busy_n++;
        end
        checks++;
        if (busy_n !== 2 + VERIFY) begin
            errors++;
            $display("FAIL b2b_busy_cycles: got %0d required %0d", busy_n, 2 + VERIFY);
        end
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        if (mem_read1 && mem_write1) both++;
        checks++;
        if (mem_read1 !== 1'b1 || address1 !== 5'd5 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load_issue: got rd=%b addr=%0d busy=%b required 1/5/1",
                     mem_read1, address1, busy1);
        end
        @(negedge clk);
        if (mem_read1 && mem_write1) both++;
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== 32'd7) begin
            errors++;
            $display("FAIL b2b_load_data: got rsp=%b rdata=%0d required 1/7", rsp_valid1, rsp_rdata1);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL b2b_strobe_overlap: got %0d overlapping cycles required 0", both);
        end
        @(negedge clk);
    endtask

    task automatic test_rd_lat2();
        int seen = 0;
        req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 5'd3; req_wdata2 = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid2) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL lat2_store_rsp: got no response required one");
        end
        @(negedge clk);
        req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 5'd3;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read2, rsp_valid2} !== 2'b10) begin
            errors++;
            $display("FAIL lat2_cycle1: got rd/rsp=%b required 10", {mem_read2, rsp_valid2});
        end
        @(negedge clk);
        checks++;
        if ({mem_read2, rsp_valid2} !== 2'b10) begin
            errors++;
            $display("FAIL lat2_cycle2: got rd/rsp=%b required 10", {mem_read2, rsp_valid2});
        end
        @(negedge clk);
        checks++;
        if ({mem_read2, rsp_valid2} !== 2'b01 || rsp_rdata2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lat2_rsp: got rd/rsp=%b rdata=%h required 01/deadbeef",
                     {mem_read2, rsp_valid2}, rsp_rdata2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int stray = 0;
        req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 5'd3;
        @(posedge clk);
        #1 reset2 = 1'b1; req_addr2 = 5'd7;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_read2, req_ready2, rsp_valid2} !== 3'b010 || address2 !== 5'd0) begin
            errors++;
            $display("FAIL midrst_state: got rd/ready/rsp=%b addr=%0d required 010/0",
                     {mem_read2, req_ready2, rsp_valid2}, address2);
        end
        @(posedge clk);
        #1 reset2 = 1'b0; req_valid2 = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read2, busy2} !== 2'b00 || address2 !== 5'd0) begin
            errors++;
            $display("FAIL midrst_no_accept: got rd/busy=%b addr=%0d required 00/0",
                     {mem_read2, busy2}, address2);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid2 || mem_read2 || mem_write2) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midrst_dropped: got %0d active cycles required 0", stray);
        end
    endtask

`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    task automatic test_write_verify();
        logic [31:0] wd [2];
        logic        er [2];
        wd[0] = 32'h1; er[0] = 1'b1;
        wd[1] = 32'h2; er[1] = 1'b0;
        stuck = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 5'd9; req_wdata1 = wd[k];
            @(posedge clk);
            #1 req_valid1 = 1'b0;
            @(negedge clk);
            checks++;
            if ({mem_write1, mem_read1} !== 2'b10) begin
                errors++;
                $display("FAIL verify_write%0d: got wr/rd=%b required 10", k,
                         {mem_write1, mem_read1});
            end
            @(negedge clk);
            checks++;
            if ({mem_write1, mem_read1} !== 2'b01) begin
                errors++;
                $display("FAIL verify_read%0d: got wr/rd=%b required 01", k,
                         {mem_write1, mem_read1});
            end
            @(negedge clk);
            checks++;
            if (rsp_valid1 !== 1'b1 || rsp_err1 !== er[k]) begin
                errors++;
                $display("FAIL verify_err%0d: got rsp=%b err=%b required 1/%b", k,
                         rsp_valid1, rsp_err1, er[k]);
            end
            @(negedge clk);
        end
        stuck = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_rd_lat2();
        test_reset_mid_read();
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
        test_write_verify();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
